// File: rtl/au_pkg.sv
// au_pkg: shared widths, opcode encodings and state enum for the arithmetic unit.
// The divider datapath is only built when AU_DIV_EN is defined.
package au_pkg;
    localparam int DATA_WIDTH   = 16;
    localparam int OPCODE_WIDTH = 4;
    localparam int CNT_W        = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } au_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [DATA_WIDTH-1:0] DIV0_RESULT = '1;
endpackage

// File: rtl/au_muldiv_core.sv
// au_muldiv_core: shared shift engine, shift-add multiply or restoring divide, one bit per step.
// The restoring-divide step exists only when AU_DIV_EN is defined; otherwise DIV yields 0.
module au_muldiv_core
    import au_pkg::*;
(
    input  logic                  Global_clk,
    input  logic                  Global_rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);
    logic                  div_q;
    logic [DATA_WIDTH-1:0] r, q, d;

`ifdef AU_DIV_EN
    logic [DATA_WIDTH:0] trial;
    assign trial = {r, q[DATA_WIDTH-1]} - {1'b0, d};
`endif

    // r: product accumulator / remainder, q: multiplier / quotient, d: multiplicand / divisor
    always_ff @(posedge Global_clk) begin
        if (Global_rst) begin
            div_q <= 1'b0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
        end else if (start) begin
            div_q <= div;
            r     <= '0;
            q     <= div ? a : b;
            d     <= div ? b : a;
        end else if (step) begin
`ifdef AU_DIV_EN
            if (div_q) begin
                r <= trial[DATA_WIDTH] ? {r[DATA_WIDTH-2:0], q[DATA_WIDTH-1]} : trial[DATA_WIDTH-1:0];
                q <= {q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
            end else
`endif
            begin
                r <= r + (q[0] ? d : '0);
                q <= q >> 1;
                d <= d << 1;
            end
        end
    end

`ifdef AU_DIV_EN
    assign result = div_q ? q : r;
`else
    assign result = div_q ? '0 : r;
`endif
endmodule

// File: rtl/au.sv
// au: arithmetic unit with a fixed 17-edge start/ready handshake for ADD/SUB/MUL/DIV.
// Define AU_DIV_EN to build the divider; without it DIV completes with result 0.
module au
    import au_pkg::*;
(
    input  logic                    Global_clk,
    input  logic                    Global_rst,
    input  logic                    AU_op_enable,
    input  logic [OPCODE_WIDTH-1:0] Mode,
    input  logic [DATA_WIDTH-1:0]   AU_in1,
    input  logic [DATA_WIDTH-1:0]   AU_in2,
    output logic [DATA_WIDTH-1:0]   AU_out,
    output logic                    AU_ready
);
    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic                  valid_q;
    au_op_e                op_q, op_in;
    logic [DATA_WIDTH-1:0] addsub_q, core_res, done_res;
    logic                  accept, step, unused_imm;
`ifdef AU_DIV_EN
    logic                  b_zero_q;
`endif

    assign op_in      = au_op_e'(Mode[2:1]);
    assign accept     = (state == IDLE) && AU_op_enable;
    assign step       = (state == BUSY) && (cnt != CNT_W'(DATA_WIDTH));
    assign unused_imm = Mode[0];

    au_muldiv_core u_core (
        .Global_clk (Global_clk),
        .Global_rst (Global_rst),
        .start      (accept),
        .step       (step),
        .div        (op_in == OP_DIV),
        .a          (AU_in1),
        .b          (AU_in2),
        .result     (core_res)
    );

`ifdef AU_DIV_EN
    assign done_res = (op_q inside {OP_MUL, OP_DIV})
                    ? ((op_q == OP_DIV && b_zero_q) ? DIV0_RESULT : core_res) : addsub_q;
`else
    assign done_res = (op_q inside {OP_MUL, OP_DIV}) ? core_res : addsub_q;
`endif

    always_ff @(posedge Global_clk) begin
        if (Global_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            valid_q  <= 1'b0;
            op_q     <= OP_ADD;
            addsub_q <= '0;
            AU_out   <= '0;
            AU_ready <= 1'b1;
`ifdef AU_DIV_EN
            b_zero_q <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (AU_op_enable) begin
                state    <= BUSY;
                cnt      <= '0;
                valid_q  <= Mode[OPCODE_WIDTH-1];
                op_q     <= op_in;
                addsub_q <= (op_in == OP_SUB) ? AU_in1 - AU_in2 : AU_in1 + AU_in2;
                AU_ready <= 1'b0;
`ifdef AU_DIV_EN
                b_zero_q <= (AU_in2 == '0);
`endif
            end
        end else if (cnt == CNT_W'(DATA_WIDTH)) begin
            state    <= IDLE;
            cnt      <= '0;
            AU_ready <= 1'b1;
            if (valid_q)
                AU_out <= done_res;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_au.sv
// tb_au: table-driven and randomized checks of au against a plain-arithmetic reference model.
// Expected DIV results follow AU_DIV_EN as defined for the build.
module tb_au;
    logic        clk = 1'b0;
    logic        rst, en, ready;
    logic [3:0]  mode;
    logic [15:0] a, b, out;
    logic [15:0] model_out;
    int          errs = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0]  m;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t tv[9];

    always #5 clk = ~clk;

    au dut (
        .Global_clk   (clk),
        .Global_rst   (rst),
        .AU_op_enable (en),
        .Mode         (mode),
        .AU_in1       (a),
        .AU_in2       (b),
        .AU_out       (out),
        .AU_ready     (ready)
    );

    task automatic chk(input string name, input string what, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s_%s: got %h expected %h", name, what, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [3:0] m, input logic [15:0] x, input logic [15:0] y,
                                              input logic [15:0] prev);
        int unsigned ux = x;
        int unsigned uy = y;
        if (!m[3]) return prev;
        case (m[2:1])
            2'b00: return 16'((ux + uy) % 65536);
            2'b01: return 16'((ux - uy) % 65536);
            2'b10: return 16'((ux * uy) % 65536);
            default: begin
`ifdef AU_DIV_EN
                if (uy == 0) return 16'hFFFF;
                return 16'(ux / uy);
`else
                return 16'h0000;
`endif
            end
        endcase
    endfunction

    // Starts one op, optionally re-pulses enable at dup_edge, and checks ready/hold/result timing.
    task automatic run_op(input logic [3:0] m, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp, input int dup_edge, input string name);
        int   n = 0;
        logic busy_ok, hold_ok;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) begin
            checks++;
            errs++;
            $display("FAIL %s_wait: AU_ready stayed low for %0d cycles", name, n);
        end
        @(negedge clk);
        en = 1'b1; mode = m; a = x; b = y;
        @(posedge clk);
        #1;
        busy_ok = !ready;
        hold_ok = (out === model_out);
        @(negedge clk);
        en = 1'b0; mode = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        for (int k = 1; k <= 17; k++) begin
            en = (k == dup_edge);
            if (en) begin
                mode = 4'b1000; a = 16'($urandom); b = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (k <= 16) begin
                busy_ok = busy_ok && !ready;
                hold_ok = hold_ok && (out === model_out);
                @(negedge clk);
            end
        end
        en = 1'b0;
        chk(name, "busy", {15'b0, busy_ok}, 16'h1);
        chk(name, "hold", {15'b0, hold_ok}, 16'h1);
        chk(name, "result", out, exp);
        chk(name, "ready", {15'b0, ready}, 16'h1);
        model_out = exp;
    endtask

    initial begin
        tv[0] = '{4'b1000, 16'h0005, 16'h0003, 16'h0008, "add"};
        tv[1] = '{4'b1001, 16'h0005, 16'h0003, 16'h0008, "addi"};
        tv[2] = '{4'b1000, 16'hFFFF, 16'h0001, 16'h0000, "add_wrap"};
        tv[3] = '{4'b1010, 16'h0003, 16'h0005, 16'hFFFE, "sub_borrow"};
        tv[4] = '{4'b1010, 16'h1234, 16'h0234, 16'h1000, "sub"};
        tv[5] = '{4'b1100, 16'h0012, 16'h0034, 16'h03A8, "mul"};
        tv[6] = '{4'b1100, 16'h0100, 16'h0100, 16'h0000, "mul_trunc"};
`ifdef AU_DIV_EN
        tv[7] = '{4'b1110, 16'h0064, 16'h0007, 16'h000E, "div"};
        tv[8] = '{4'b1110, 16'h0064, 16'h0000, 16'hFFFF, "div_zero"};
`else
        tv[7] = '{4'b1110, 16'h0064, 16'h0007, 16'h0000, "div_off"};
        tv[8] = '{4'b1110, 16'h0064, 16'h0000, 16'h0000, "div_zero_off"};
`endif
        rst = 1'b1; en = 1'b0; mode = '0; a = '0; b = '0;
        model_out = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "out", out, 16'h0000);
        chk("reset", "ready", {15'b0, ready}, 16'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op(tv[i].m, tv[i].x, tv[i].y, tv[i].exp, 0, tv[i].name);

        run_op(4'b1000, 16'h0100, 16'h0023, 16'h0123, 0, "add_pre");
        run_op(4'b0110, 16'h0009, 16'h0003, 16'h0123, 0, "non_au");
        run_op(4'b1100, 16'h0012, 16'h0034, 16'h03A8, 5, "dup_start");

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  rm;
            logic [15:0] ra, rb;
            rm = 4'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(0, 7) == 1 ? $urandom_range(1, 20) : $urandom);
            run_op(rm, ra, rb, ref_model(rm, ra, rb, model_out), 0, "rand");
        end

        run_op(4'b1000, 16'h0005, 16'h0003, 16'h0008, 0, "add_before_rst");
        @(negedge clk);
        en = 1'b1; mode = 4'b1110; a = 16'h0064; b = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset", "out", out, 16'h0000);
        chk("mid_reset", "ready", {15'b0, ready}, 16'h1);
        @(negedge clk);
        rst = 1'b0;
        model_out = '0;
        repeat (25) @(posedge clk);
        #1;
        chk("post_reset", "out", out, 16'h0000);
        chk("post_reset", "ready", {15'b0, ready}, 16'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
